// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the clk_div_bank tick/clock generator.
//   DEFAULT_WIDTH : default counter/divisor width
//   DEFAULT_DIV   : default divisor loaded into every channel at reset
//   ch_idx_w()    : width of a channel index (clog2, never below 1)
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int unsigned DEFAULT_WIDTH = 25;
   localparam int unsigned DEFAULT_DIV   = 25_000_000;

   // A single-channel bank still needs a 1-bit select port.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: wrapping counter, active divisor, shadow divisor and the
// registered clkout / tick outputs. A divisor write lands in the shadow and is
// promoted only at a wrap (or immediately when the channel is stopped), so the
// counter never runs past the active divisor.
// Ports:
//   clkin   in  1      system clock (posedge)
//   rst     in  1      synchronous active-high reset
//   en      in  1      run enable
//   wr      in  1      divisor write strobe for this channel
//   wr_div  in  WIDTH  divisor value written by wr
//   pending out 1      shadow written but not yet applied
//   clkout  out 1      square wave, toggles at each wrap
//   tick    out 1      one-cycle strobe at each wrap
// -----------------------------------------------------------------------------
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH       = clk_div_pkg::DEFAULT_WIDTH,
   parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_div,
   output logic             pending,
   output logic             clkout,
   output logic             tick
);

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] count_q,   count_d;
   logic [WIDTH-1:0] div_q,     div_d;
   logic [WIDTH-1:0] shadow_q,  shadow_d;
   logic             pending_q, pending_d;
   logic             clkout_q,  clkout_d;
   logic             tick_q,    tick_d;
   logic             wrap_c;

   // A wrap only happens while running.
   assign wrap_c = en && (count_q == div_q);

   // Next-state: counting, wrap handling and divisor staging.
   always_comb begin
      count_d   = count_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      clkout_d  = clkout_q;
      tick_d    = 1'b0;

      if (en) begin
         if (wrap_c) begin
            count_d  = '0;
            clkout_d = ~clkout_q;
            tick_d   = 1'b1;
            if (pending_q) begin
               div_d     = shadow_q;
               pending_d = 1'b0;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
         end

         if (wr) begin
            shadow_d = wr_div;
            if (wrap_c) begin
               // Write coincides with the wrap: apply it straight away,
               // overriding any older staged value.
               div_d     = wr_div;
               pending_d = 1'b0;
            end else begin
               pending_d = 1'b1;
            end
         end
      end else if (wr) begin
         // Stopped channel: no period in flight, so restart cleanly.
         div_d     = wr_div;
         shadow_d  = wr_div;
         count_d   = '0;
         pending_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clkin) begin
      if (rst) begin
         count_q   <= '0;
         div_q     <= RST_DIV;
         shadow_q  <= RST_DIV;
         pending_q <= 1'b0;
         clkout_q  <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         clkout_q  <= clkout_d;
         tick_q    <= tick_d;
      end
   end

   assign pending = pending_q;
   assign clkout  = clkout_q;
   assign tick    = tick_q;

endmodule : clk_div_channel

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of independent programmable clock dividers / tick generators.
// Ports:
//   clkin     in  1               system clock (posedge)
//   rst       in  1               synchronous active-high reset
//   en        in  CHANNELS        per-channel run enable
//   load      in  1               divisor write strobe
//   load_ch   in  ch_idx_w(CH)    target channel of load
//   load_div  in  WIDTH           new divisor
//   pending   out CHANNELS        divisor staged, not yet applied
//   clkout    out CHANNELS        divided clock, period 2*(div+1)
//   tick      out CHANNELS        one-cycle strobe, period div+1
// -----------------------------------------------------------------------------
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned WIDTH       = clk_div_pkg::DEFAULT_WIDTH,
   parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
   input  logic                              clkin,
   input  logic                              rst,
   input  logic [CHANNELS-1:0]               en,
   input  logic                              load,
   input  logic [ch_idx_w(CHANNELS)-1:0]     load_ch,
   input  logic [WIDTH-1:0]                  load_div,
   output logic [CHANNELS-1:0]               pending,
   output logic [CHANNELS-1:0]               clkout,
   output logic [CHANNELS-1:0]               tick
);

   localparam int unsigned CH_W = ch_idx_w(CHANNELS);

   logic                ch_ok_c;
   logic [CHANNELS-1:0] wr_c;

   // Indices past the last channel are dropped (non power-of-two banks).
   assign ch_ok_c = (32'(load_ch) < CHANNELS);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign wr_c[i] = load && ch_ok_c && (load_ch == CH_W'(i));

      clk_div_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clkin   (clkin),
         .rst     (rst),
         .en      (en[i]),
         .wr      (wr_c[i]),
         .wr_div  (load_div),
         .pending (pending[i]),
         .clkout  (clkout[i]),
         .tick    (tick[i])
      );
   end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Self-checking bench: main bank (2 channels, 8-bit, div 3) with a cycle model
// feeding an expected-value queue, a vector table for free-running, and directed
// sequences; a 3-channel bank covers the out-of-range channel select.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (CHANNELS=2)
   logic       rst;
   logic [1:0] en;
   logic       load;
   logic [0:0] load_ch;
   logic [7:0] load_div;
   logic [1:0] pending, clkout, tick;

   // Second DUT (CHANNELS=3) for out-of-range index
   logic [2:0] en3;
   logic       load3;
   logic [1:0] load_ch3;
   logic [7:0] load_div3;
   logic [2:0] pending3, clkout3, tick3;

   clk_div_bank #(.CHANNELS(2), .WIDTH(8), .DEFAULT_DIV(3)) dut (
      .clkin(clk), .rst(rst), .en(en), .load(load), .load_ch(load_ch),
      .load_div(load_div), .pending(pending), .clkout(clkout), .tick(tick)
   );

   clk_div_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3)) dut3 (
      .clkin(clk), .rst(rst), .en(en3), .load(load3), .load_ch(load_ch3),
      .load_div(load_div3), .pending(pending3), .clkout(clkout3), .tick(tick3)
   );

   typedef struct packed {
      logic [1:0] tk;
      logic [1:0] ck;
      logic [1:0] pd;
   } obs_t;

   typedef struct {
      logic [1:0] en;
      logic [1:0] exp_tick;
      logic [1:0] exp_clk;
      logic [1:0] exp_pend;
   } vec_t;

   obs_t exp_q[$];

   // Reference model state
   logic [7:0] m_cnt [2];
   logic [7:0] m_div [2];
   logic [7:0] m_sh  [2];
   logic       m_pend[2];
   logic       m_clk [2];
   logic       m_tick[2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [1:0] e, input logic ld,
                             input logic [0:0] ch, input logic [7:0] dv);
      for (int c = 0; c < 2; c++) begin
         logic wr, wrap;
         if (r) begin
            m_cnt[c] = 8'd0; m_div[c] = 8'd3; m_sh[c] = 8'd3;
            m_pend[c] = 1'b0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
         end else begin
            wr   = ld && (int'(ch) == c);
            wrap = e[c] && (m_cnt[c] == m_div[c]);
            if (!e[c]) begin
               m_tick[c] = 1'b0;
               if (wr) begin
                  m_div[c] = dv; m_sh[c] = dv; m_cnt[c] = 8'd0; m_pend[c] = 1'b0;
               end
            end else if (wrap) begin
               m_cnt[c] = 8'd0; m_clk[c] = ~m_clk[c]; m_tick[c] = 1'b1;
               if (wr) begin
                  m_div[c] = dv; m_sh[c] = dv; m_pend[c] = 1'b0;
               end else if (m_pend[c]) begin
                  m_div[c] = m_sh[c]; m_pend[c] = 1'b0;
               end
            end else begin
               m_cnt[c] = m_cnt[c] + 8'd1; m_tick[c] = 1'b0;
               if (wr) begin
                  m_sh[c] = dv; m_pend[c] = 1'b1;
               end
            end
         end
      end
   endtask

   // Drive one cycle, queue the model's prediction, compare after the edge.
   task automatic step(input logic r, input logic [1:0] e, input logic ld,
                       input logic [0:0] ch, input logic [7:0] dv);
      obs_t exp_o, got;
      rst = r; en = e; load = ld; load_ch = ch; load_div = dv;
      model_step(r, e, ld, ch, dv);
      exp_q.push_back({m_tick[1], m_tick[0], m_clk[1], m_clk[0], m_pend[1], m_pend[0]});
      @(posedge clk);
      #1;
      cyc++;
      got   = {tick, clkout, pending};
      exp_o = exp_q.pop_front();
      n_tests++;
      if (got !== exp_o) begin
         n_fail++;
         $display("FAIL scoreboard (cycle %0d): got tick=%b clkout=%b pending=%b, expected tick=%b clkout=%b pending=%b",
                  cyc, got.tk, got.ck, got.pd, exp_o.tk, exp_o.ck, exp_o.pd);
      end
   endtask

   task automatic run(input logic [1:0] e);
      step(1'b0, e, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic wait_tick(input int c);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         run(2'b11);
         if (tick[c]) seen = 1'b1;
      end
      chk("wait_tick_timeout", 8'(seen), 8'd1);
   endtask

   initial begin
      vec_t       vt[16];
      logic       held, prev, nxt, t0, t1, p0, p1, c1;
      logic [1:0] t2;
      logic [2:0] t3;

      rst = 1'b1; en = 2'b00; load = 1'b0; load_ch = 1'b0; load_div = 8'd0;
      en3 = 3'b000; load3 = 1'b0; load_ch3 = 2'd0; load_div3 = 8'd0;

      // Free-running vectors: div 3 -> tick every 4th edge, clkout period 8
      for (int k = 1; k <= 16; k++) begin
         vt[k-1].en       = 2'b11;
         vt[k-1].exp_tick = (k % 4 == 0) ? 2'b11 : 2'b00;
         vt[k-1].exp_clk  = (((k / 4) % 2) == 1) ? 2'b11 : 2'b00;
         vt[k-1].exp_pend = 2'b00;
      end

      // T1: reset, then both channels free-running
      step(1'b1, 2'b11, 1'b1, 1'b0, 8'd7);
      chk("rst_outputs", {2'b00, tick, clkout, pending}, 8'h00);
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 16; i++) begin
         run(vt[i].en);
         chk("t1_tick",    8'(tick),    8'(vt[i].exp_tick));
         chk("t1_clkout",  8'(clkout),  8'(vt[i].exp_clk));
         chk("t1_pending", 8'(pending), 8'(vt[i].exp_pend));
      end

      // T3: two loads before a wrap, only the last one applies (ch0 count=0 now)
      run(2'b11);
      step(1'b0, 2'b11, 1'b1, 1'b0, 8'd5);
      p0 = pending[0]; chk("t3_pend_after_5", 8'(p0), 8'd1);
      step(1'b0, 2'b11, 1'b1, 1'b0, 8'd2);
      p0 = pending[0]; chk("t3_pend_after_2", 8'(p0), 8'd1);
      run(2'b11);
      t0 = tick[0]; p0 = pending[0];
      chk("t3_wrap_tick", 8'(t0), 8'd1);
      chk("t3_pend_clear", 8'(p0), 8'd0);
      for (int i = 1; i <= 6; i++) begin
         run(2'b11);
         t0 = tick[0]; p0 = pending[0];
         chk("t3_period3", 8'(t0), (i % 3 == 0) ? 8'd1 : 8'd0);
         chk("t3_pend_stays0", 8'(p0), 8'd0);
      end

      // T2: load div=1 at count=1 (ch0 div=2, count=0 now)
      run(2'b11);
      step(1'b0, 2'b11, 1'b1, 1'b0, 8'd1);
      p0 = pending[0]; chk("t2_pend_set", 8'(p0), 8'd1);
      run(2'b11);
      t0 = tick[0]; p0 = pending[0];
      chk("t2_wrap_tick", 8'(t0), 8'd1);
      chk("t2_pend_clear", 8'(p0), 8'd0);
      for (int i = 1; i <= 4; i++) begin
         run(2'b11);
         t0 = tick[0];
         chk("t2_period2", 8'(t0), (i % 2 == 0) ? 8'd1 : 8'd0);
      end

      // T4: load div=0 exactly on the wrap cycle (ch0 div=1, count=0 now)
      run(2'b11);
      step(1'b0, 2'b11, 1'b1, 1'b0, 8'd0);
      t0 = tick[0]; p0 = pending[0];
      chk("t4_wrap_tick", 8'(t0), 8'd1);
      chk("t4_no_pend", 8'(p0), 8'd0);
      for (int i = 0; i < 6; i++) begin
         prev = clkout[0];
         run(2'b11);
         t0 = tick[0]; p0 = pending[0]; c1 = clkout[0]; nxt = ~prev;
         chk("t4_tick_const", 8'(t0), 8'd1);
         chk("t4_no_pend_run", 8'(p0), 8'd0);
         chk("t4_clk_toggle", 8'(c1), 8'(nxt));
      end

      // T5: stop ch1 at count=2, load while stopped, restart
      wait_tick(1);
      run(2'b11);
      run(2'b11);
      held = clkout[1];
      for (int i = 0; i < 3; i++) begin
         run(2'b01);
         t1 = tick[1]; c1 = clkout[1]; t0 = tick[0];
         chk("t5_tick1_off", 8'(t1), 8'd0);
         chk("t5_clk1_held", 8'(c1), 8'(held));
         chk("t5_ch0_tick", 8'(t0), 8'd1);
      end
      step(1'b0, 2'b01, 1'b1, 1'b1, 8'd6);
      p1 = pending[1]; c1 = clkout[1];
      chk("t5_no_pend_disabled", 8'(p1), 8'd0);
      chk("t5_clk1_held_load", 8'(c1), 8'(held));
      for (int i = 1; i <= 7; i++) begin
         run(2'b11);
         t1 = tick[1]; t0 = tick[0];
         chk("t5_first_tick_7", 8'(t1), (i == 7) ? 8'd1 : 8'd0);
         chk("t5_ch0_tick_run", 8'(t0), 8'd1);
      end

      // T6: reset with a staged divisor and a load in the same cycle
      step(1'b0, 2'b11, 1'b1, 1'b1, 8'd2);
      p1 = pending[1]; chk("t6_pend_before_rst", 8'(p1), 8'd1);
      step(1'b1, 2'b11, 1'b1, 1'b1, 8'd9);
      chk("t6_rst_outputs", {2'b00, tick, clkout, pending}, 8'h00);
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'd0);
      for (int i = 1; i <= 4; i++) begin
         run(2'b11);
         t2 = tick;
         chk("t6_default_div", 8'(t2), (i == 4) ? 8'h3 : 8'h0);
      end

      // Out-of-range channel select on the 3-channel bank
      en3 = 3'b111;
      run(2'b11);
      load3 = 1'b1; load_ch3 = 2'd3; load_div3 = 8'd1;
      run(2'b11);
      load3 = 1'b0;
      t3 = pending3; chk("oor_no_pending", 8'(t3), 8'h0);
      run(2'b11);
      t3 = tick3; chk("oor_no_early_tick", 8'(t3), 8'h0);
      run(2'b11);
      t3 = tick3; chk("oor_tick_unchanged", 8'(t3), 8'h7);
      load3 = 1'b1; load_ch3 = 2'd2; load_div3 = 8'd1;
      run(2'b11);
      load3 = 1'b0;
      t3 = pending3; chk("in_range_pending", 8'(t3), 8'h4);

      chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_clk_div_bank
